// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running up-counter: locks onto the +1 (mod 2^CNT_W)
// sequence of cnt and reports skips/stalls (errors) and MAX->0 wrap-arounds.
module count_seq_checker #(
    parameter int CNT_W  = 4,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              cnt_valid,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [CNT_W-1:0]  expected
);

    localparam int                   MATCH_W    = $clog2(LOCK_N + 1);
    localparam logic [MATCH_W-1:0]   LOCK_MATCH = MATCH_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        LOCKED  = 2'd2,
        ILLEGAL = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    last_q,      last_d;
    logic [MATCH_W-1:0]  match_q,     match_d;
    logic                locked_q,    locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]    err_cnt_q,   err_cnt_d;
    logic [WRAP_W-1:0]   wrap_cnt_q,  wrap_cnt_d;
    logic [CNT_W-1:0]    expected_q,  expected_d;

    logic [CNT_W-1:0]    last_inc;
    logic [CNT_W-1:0]    cnt_inc;
    logic [MATCH_W-1:0]  match_inc;
    logic                sample_ok;

    assign last_inc  = last_q + CNT_W'(1);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign match_inc = match_q + MATCH_W'(1);
    assign sample_ok = (cnt == last_inc);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        last_d      = last_q;
        match_d     = match_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        wrap_cnt_d  = wrap_cnt_q;
        expected_d  = expected_q;

        case (state_q)
            IDLE: begin
                if (cnt_valid) begin
                    last_d     = cnt;
                    expected_d = cnt_inc;
                    match_d    = '0;
                    state_d    = SYNC;
                end
            end
            SYNC: begin
                if (cnt_valid) begin
                    last_d     = cnt;
                    expected_d = cnt_inc;
                    if (sample_ok) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_MATCH) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (cnt_valid) begin
                    last_d     = cnt;
                    expected_d = cnt_inc;
                    if (sample_ok) begin
                        // A correct sample after MAX is necessarily 0, so last==MAX marks a wrap.
                        if (last_q == '1) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                    end else begin
                        state_d     = SYNC;
                        match_d     = '0;
                        locked_d    = 1'b0;
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                match_d  = '0;
                locked_d = 1'b0;
            end
        endcase

        if (clr_stats) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= '0;
            match_q     <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            expected_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
            expected_q  <= expected_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_cnt_q;
    assign wrap_count = wrap_cnt_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed plus randomized bench for count_seq_checker; a sample-level reference model
// tracks last value, run length of correct increments, lock flag and statistics.
module tb_count_seq_checker;

    localparam int CNT_W   = 4;
    localparam int LOCK_N  = 2;
    localparam int ERR_W   = 2;
    localparam int WRAP_W  = 8;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int WRAP_MOD = 1 << WRAP_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CNT_W-1:0]  cnt = '0;
    logic              cnt_valid = 1'b0;
    logic              clr_stats = 1'b0;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;
    logic [CNT_W-1:0]  expected;

    count_seq_checker #(
        .CNT_W (CNT_W),
        .LOCK_N(LOCK_N),
        .ERR_W (ERR_W),
        .WRAP_W(WRAP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt       (cnt),
        .cnt_valid (cnt_valid),
        .clr_stats (clr_stats),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .wrap_count(wrap_count),
        .expected  (expected)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the checker should report, from the sequence rules alone.
    bit m_have  = 0;
    int m_last  = 0;
    int m_run   = 0;
    bit m_lock  = 0;
    bit m_pulse = 0;
    int m_err   = 0;
    int m_wrap  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model(input bit rst, input bit v, input int c, input bit clr);
        m_pulse = 0;
        if (rst) begin
            m_have = 0; m_last = 0; m_run = 0; m_lock = 0; m_err = 0; m_wrap = 0;
        end else begin
            if (v) begin
                if (!m_have) begin
                    m_have = 1;
                    m_run  = 0;
                end else if (m_lock) begin
                    if (c == (m_last + 1) % CNT_MOD) begin
                        if (c == 0) m_wrap = (m_wrap + 1) % WRAP_MOD;
                    end else begin
                        m_lock  = 0;
                        m_run   = 0;
                        m_pulse = 1;
                        if (m_err < ERR_MAX) m_err++;
                    end
                end else begin
                    if (c == (m_last + 1) % CNT_MOD) begin
                        m_run++;
                        if (m_run >= LOCK_N) m_lock = 1;
                    end else begin
                        m_run = 0;
                    end
                end
                m_last = c;
            end
            if (clr) begin
                m_err  = 0;
                m_wrap = 0;
            end
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit v, input int c, input bit clr);
        @(negedge clk);
        reset     = rst;
        cnt_valid = v;
        cnt       = CNT_W'(c);
        clr_stats = clr;
        model(rst, v, c, clr);
        @(posedge clk);
        #1;
        chk({tag, ".locked"},     32'(locked),     32'(m_lock));
        chk({tag, ".err_pulse"},  32'(err_pulse),  32'(m_pulse));
        chk({tag, ".err_count"},  32'(err_count),  32'(m_err));
        chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(m_wrap));
        chk({tag, ".expected"},   32'(expected),   32'(m_have ? (m_last + 1) % CNT_MOD : 0));
    endtask

    initial begin
        // Reset hold with a toggling count.
        for (int i = 0; i < 3; i++) step("reset_hold", 1, 1, i * 5, 0);
        chk("reset_expected0", 32'(expected), 32'd0);

        // Acquire lock on 3,4,5.
        step("lock3", 0, 1, 3, 0);
        step("lock4", 0, 1, 4, 0);
        chk("not_locked_yet", 32'(locked), 32'd0);
        step("lock5", 0, 1, 5, 0);
        chk("locked_after_5", 32'(locked), 32'd1);
        chk("expected_6", 32'(expected), 32'd6);

        // Run up through MAX->0 while locked.
        for (int v = 6; v <= 15; v++) step("run_up", 0, 1, v, 0);
        step("wrap0", 0, 1, 0, 0);
        step("wrap1", 0, 1, 1, 0);
        chk("wrap_count_1", 32'(wrap_count), 32'd1);
        chk("wrap_still_locked", 32'(locked), 32'd1);

        // Skip error 7 -> 9, then relock on 10, 11.
        for (int v = 2; v <= 7; v++) step("to7", 0, 1, v, 0);
        step("skip9", 0, 1, 9, 0);
        chk("skip_pulse", 32'(err_pulse), 32'd1);
        chk("skip_err1", 32'(err_count), 32'd1);
        chk("skip_unlocked", 32'(locked), 32'd0);
        step("relock10", 0, 1, 10, 0);
        chk("pulse_one_cycle", 32'(err_pulse), 32'd0);
        step("relock11", 0, 1, 11, 0);
        chk("relocked", 32'(locked), 32'd1);

        // Drive the 2-bit error counter into saturation.
        for (int k = 0; k < 4; k++) begin
            step("sat_err", 0, 1, (m_last + 3) % CNT_MOD, 0);
            step("sat_re1", 0, 1, (m_last + 1) % CNT_MOD, 0);
            step("sat_re2", 0, 1, (m_last + 1) % CNT_MOD, 0);
        end
        chk("err_saturated", 32'(err_count), 32'd3);
        step("clr_with_err", 0, 1, (m_last + 3) % CNT_MOD, 1);
        chk("clr_wins", 32'(err_count), 32'd0);
        chk("clr_keeps_pulse", 32'(err_pulse), 32'd1);
        step("clr_re1", 0, 1, (m_last + 1) % CNT_MOD, 0);
        step("clr_re2", 0, 1, (m_last + 1) % CNT_MOD, 0);

        // Gaps in cnt_valid, then a stalled (repeated) value.
        for (int k = 0; k < 5; k++) step("gap", 0, 0, $urandom_range(0, CNT_MOD - 1), 0);
        chk("gap_locked", 32'(locked), 32'd1);
        for (int k = 0; k < CNT_MOD && m_last != 6; k++) step("to6", 0, 1, (m_last + 1) % CNT_MOD, 0);
        step("repeat6", 0, 1, 6, 0);
        chk("stall_pulse", 32'(err_pulse), 32'd1);
        step("sync7", 0, 1, 7, 0);
        step("mid_sync_reset", 1, 1, 8, 0);
        chk("rst_locked0", 32'(locked), 32'd0);
        chk("rst_expected0", 32'(expected), 32'd0);

        // Randomized traffic: mostly in-sequence, with skips, stalls, gaps, clears, resets.
        for (int k = 0; k < 400; k++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 99));
            c = (r < 80) ? (m_last + 1) % CNT_MOD : int'($urandom_range(0, CNT_MOD - 1));
            step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), c,
                 ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
